// File: rtl/rx_auth_pkg.sv
// Shared widths, frame field offsets and FSM state encoding for the rx_auth_manager receive path.
package rx_auth_pkg;

  localparam int unsigned DEF_PLAINTEXT_WIDTH          = 488;
  localparam int unsigned DEF_FRAMER_CNTR_WIDTH        = 16;
  localparam int unsigned DEF_FRAMER_AUTH_WIDTH        = 8;
  localparam int unsigned DEF_CHACHA_KEY_WIDTH         = 256;
  localparam int unsigned DEF_CHACHA_NONCE_WIDTH       = 96;
  localparam int unsigned DEF_CHACHA_BLOCK_COUNT_WIDTH = 32;
  localparam int unsigned DEF_OUT_FIFO_DEPTH           = 4;
  localparam int unsigned DEF_DROP_CNT_WIDTH           = 16;

  // Default decrypted frame layout: {plaintext, counter, tag}
  localparam int unsigned DEF_AUTH_LSB = 0;
  localparam int unsigned DEF_CNTR_LSB = DEF_FRAMER_AUTH_WIDTH;
  localparam int unsigned DEF_PT_LSB   = DEF_FRAMER_CNTR_WIDTH + DEF_FRAMER_AUTH_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_CHECK    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_auth_manager_fifo.sv
// rx_plaintext_fifo: first-word-fall-through plaintext queue; push and pop may coincide even when full.
module rx_plaintext_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 488
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = AW'(wr_ptr_q + AW'(1));
    end
    if (do_pop) begin
      rd_ptr_d = AW'(rd_ptr_q + AW'(1));
    end
    count_d = CW'(count_q + CW'(do_push) - CW'(do_pop));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rx_auth_manager.sv
// Receive-path manager: one ChaCha decryption per frame, tag check, FIFO toward the master.
// Optional replay-window check is built when RX_REPLAY_CHECK_EN is defined.
module rx_auth_manager
  import rx_auth_pkg::*;
#(
  parameter int unsigned PLAINTEXT_WIDTH          = DEF_PLAINTEXT_WIDTH,
  parameter int unsigned FRAMER_CNTR_WIDTH        = DEF_FRAMER_CNTR_WIDTH,
  parameter int unsigned FRAMER_AUTH_WIDTH        = DEF_FRAMER_AUTH_WIDTH,
  parameter int unsigned FRAMED_DATA_WIDTH        = PLAINTEXT_WIDTH + FRAMER_CNTR_WIDTH + FRAMER_AUTH_WIDTH,
  parameter int unsigned CHACHA_KEY_WIDTH         = DEF_CHACHA_KEY_WIDTH,
  parameter int unsigned CHACHA_NONCE_WIDTH       = DEF_CHACHA_NONCE_WIDTH,
  parameter int unsigned CHACHA_BLOCK_COUNT_WIDTH = DEF_CHACHA_BLOCK_COUNT_WIDTH,
  parameter int unsigned OUT_FIFO_DEPTH           = DEF_OUT_FIFO_DEPTH,
  parameter int unsigned DROP_CNT_WIDTH           = DEF_DROP_CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic [FRAMED_DATA_WIDTH-1:0]        slave2manager_cyphertext,
  input  logic                                slave2manager_valid,
  output logic                                manager2slave_ready,
  input  logic [CHACHA_KEY_WIDTH-1:0]         cfg_key,
  input  logic [CHACHA_NONCE_WIDTH-1:0]       cfg_nonce,
  input  logic [FRAMER_AUTH_WIDTH-1:0]        cfg_auth_tag,
  output logic [CHACHA_KEY_WIDTH-1:0]         manager2chacha_key,
  output logic [CHACHA_NONCE_WIDTH-1:0]       manager2chacha_nonce,
  output logic [FRAMED_DATA_WIDTH-1:0]        manager2chacha_framed_cyphertext,
  output logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] manager2chacha_block_count,
  output logic                                manager2chacha_start,
  input  logic                                chacha2manager_ready,
  input  logic                                chacha2manager_valid,
  input  logic [FRAMED_DATA_WIDTH-1:0]        chacha2manager_decrypted_msg,
  output logic [PLAINTEXT_WIDTH-1:0]          manager2master_plaintext,
  output logic                                manager2master_valid,
  input  logic                                master2manager_ready,
  output logic [DROP_CNT_WIDTH-1:0]           drop_auth_cnt,
  output logic [DROP_CNT_WIDTH-1:0]           drop_replay_cnt
);

  localparam int unsigned CNTR_LSB = FRAMER_AUTH_WIDTH;
  localparam int unsigned PT_LSB   = FRAMER_CNTR_WIDTH + FRAMER_AUTH_WIDTH;

  rx_state_e                         state_q, state_d;
  logic                              init_done_q;
  logic [FRAMED_DATA_WIDTH-1:0]      ct_q, ct_d;
  logic [CHACHA_KEY_WIDTH-1:0]       key_q, key_d;
  logic [CHACHA_NONCE_WIDTH-1:0]     nonce_q, nonce_d;
  logic [FRAMER_AUTH_WIDTH-1:0]      exp_tag_q, exp_tag_d;
  logic [PLAINTEXT_WIDTH-1:0]        pt_q, pt_d;
  logic [FRAMER_AUTH_WIDTH-1:0]      rx_tag_q, rx_tag_d;
  logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] blk_q, blk_d;
  logic [DROP_CNT_WIDTH-1:0]         drop_auth_q, drop_auth_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic tag_ok, fresh;

`ifdef RX_REPLAY_CHECK_EN
  logic [FRAMER_CNTR_WIDTH-1:0] rx_cntr_q, rx_cntr_d;
  logic [FRAMER_CNTR_WIDTH-1:0] last_cntr_q, last_cntr_d;
  logic [FRAMER_CNTR_WIDTH-1:0] cntr_delta;
  logic                         hist_valid_q, hist_valid_d;
  logic [DROP_CNT_WIDTH-1:0]    drop_replay_q, drop_replay_d;

  // Fresh iff forward distance from last accepted counter is in [1, half range)
  assign cntr_delta      = FRAMER_CNTR_WIDTH'(rx_cntr_q - last_cntr_q);
  assign fresh           = !hist_valid_q ||
                           ((cntr_delta != '0) && !cntr_delta[FRAMER_CNTR_WIDTH-1]);
  assign drop_replay_cnt = drop_replay_q;
`else
  logic unused_cntr_field;

  assign unused_cntr_field = ^chacha2manager_decrypted_msg[CNTR_LSB +: FRAMER_CNTR_WIDTH];
  assign fresh             = 1'b1;
  assign drop_replay_cnt   = '0;
`endif

  assign tag_ok   = (rx_tag_q == exp_tag_q);
  assign fifo_pop = manager2master_valid && master2manager_ready;

  assign manager2chacha_key               = key_q;
  assign manager2chacha_nonce             = nonce_q;
  assign manager2chacha_framed_cyphertext = ct_q;
  assign manager2chacha_block_count       = blk_q;
  assign manager2master_valid             = !fifo_empty;
  assign drop_auth_cnt                    = drop_auth_q;

  always_comb begin
    state_d              = state_q;
    ct_d                 = ct_q;
    key_d                = key_q;
    nonce_d              = nonce_q;
    exp_tag_d            = exp_tag_q;
    pt_d                 = pt_q;
    rx_tag_d             = rx_tag_q;
    blk_d                = blk_q;
    drop_auth_d          = drop_auth_q;
    fifo_push            = 1'b0;
    manager2slave_ready  = 1'b0;
    manager2chacha_start = 1'b0;
`ifdef RX_REPLAY_CHECK_EN
    rx_cntr_d            = rx_cntr_q;
    last_cntr_d          = last_cntr_q;
    hist_valid_d         = hist_valid_q;
    drop_replay_d        = drop_replay_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        manager2slave_ready = init_done_q;
        if (slave2manager_valid && init_done_q) begin
          ct_d      = slave2manager_cyphertext;
          key_d     = cfg_key;
          nonce_d   = cfg_nonce;
          exp_tag_d = cfg_auth_tag;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        manager2chacha_start = chacha2manager_ready;
        if (chacha2manager_ready) state_d = ST_WAIT_DEC;
      end
      ST_WAIT_DEC: begin
        if (chacha2manager_valid) begin
          pt_d     = chacha2manager_decrypted_msg[PT_LSB +: PLAINTEXT_WIDTH];
          rx_tag_d = chacha2manager_decrypted_msg[FRAMER_AUTH_WIDTH-1:0];
`ifdef RX_REPLAY_CHECK_EN
          rx_cntr_d = chacha2manager_decrypted_msg[CNTR_LSB +: FRAMER_CNTR_WIDTH];
`endif
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Tag failure wins over replay failure; a passing frame waits for FIFO room
        if (!tag_ok) begin
          if (!(&drop_auth_q)) drop_auth_d = DROP_CNT_WIDTH'(drop_auth_q + DROP_CNT_WIDTH'(1));
          state_d = ST_IDLE;
        end else if (!fresh) begin
`ifdef RX_REPLAY_CHECK_EN
          if (!(&drop_replay_q)) drop_replay_d = DROP_CNT_WIDTH'(drop_replay_q + DROP_CNT_WIDTH'(1));
`endif
          state_d = ST_IDLE;
        end else if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
`ifdef RX_REPLAY_CHECK_EN
          hist_valid_d = 1'b1;
          last_cntr_d  = rx_cntr_q;
`endif
          state_d   = ST_IDLE;
        end
        if (state_d == ST_IDLE) begin
          blk_d = CHACHA_BLOCK_COUNT_WIDTH'(blk_q + CHACHA_BLOCK_COUNT_WIDTH'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      init_done_q   <= 1'b0;
      ct_q          <= '0;
      key_q         <= '0;
      nonce_q       <= '0;
      exp_tag_q     <= '0;
      pt_q          <= '0;
      rx_tag_q      <= '0;
      blk_q         <= '0;
      drop_auth_q   <= '0;
`ifdef RX_REPLAY_CHECK_EN
      rx_cntr_q     <= '0;
      last_cntr_q   <= '0;
      hist_valid_q  <= 1'b0;
      drop_replay_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      init_done_q   <= 1'b1;
      ct_q          <= ct_d;
      key_q         <= key_d;
      nonce_q       <= nonce_d;
      exp_tag_q     <= exp_tag_d;
      pt_q          <= pt_d;
      rx_tag_q      <= rx_tag_d;
      blk_q         <= blk_d;
      drop_auth_q   <= drop_auth_d;
`ifdef RX_REPLAY_CHECK_EN
      rx_cntr_q     <= rx_cntr_d;
      last_cntr_q   <= last_cntr_d;
      hist_valid_q  <= hist_valid_d;
      drop_replay_q <= drop_replay_d;
`endif
    end
  end

  rx_plaintext_fifo #(
    .DEPTH (OUT_FIFO_DEPTH),
    .WIDTH (PLAINTEXT_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (pt_q),
    .rdata  (manager2master_plaintext),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: doc/rx_auth_manager.md
# rx_auth_manager

Parametrised successor of the receiver manager on the message-authentication receive path. Accepts framed ciphertext from the link slave, drives one ChaCha decryption per frame and deframes the result into plaintext, counter and auth tag. Checks the tag and, optionally, counter freshness (replay window). Queues passing plaintexts in an output FIFO toward the master and counts dropped frames.

## Interface
Parameters:
- PLAINTEXT_WIDTH, 488, plaintext field bits
- FRAMER_CNTR_WIDTH, 16, frame counter field bits
- FRAMER_AUTH_WIDTH, 8, auth tag field bits
- FRAMED_DATA_WIDTH, PLAINTEXT_WIDTH+FRAMER_CNTR_WIDTH+FRAMER_AUTH_WIDTH (512), derived, do not override
- CHACHA_KEY_WIDTH, 256; CHACHA_NONCE_WIDTH, 96; CHACHA_BLOCK_COUNT_WIDTH, 32
- OUT_FIFO_DEPTH, 4, plaintext FIFO entries, power of two, ≥2
- DROP_CNT_WIDTH, 16, drop counter bits

Ports:
- clk  in  1  single clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- slave2manager_cyphertext  in  FRAMED_DATA_WIDTH  framed ciphertext
- slave2manager_valid  in  1  ciphertext valid
- manager2slave_ready  out  1  manager can accept a frame
- cfg_key  in  CHACHA_KEY_WIDTH  key, sampled at slave handshake
- cfg_nonce  in  CHACHA_NONCE_WIDTH  nonce, sampled at slave handshake
- cfg_auth_tag  in  FRAMER_AUTH_WIDTH  expected tag, sampled at slave handshake
- manager2chacha_key / _nonce / _framed_cyphertext / _block_count  out  widths as params  ChaCha request fields
- manager2chacha_start  out  1  one-cycle request pulse
- chacha2manager_ready  in  1  ChaCha idle
- chacha2manager_valid  in  1  decrypted result valid (one-cycle pulse)
- chacha2manager_decrypted_msg  in  FRAMED_DATA_WIDTH  decrypted frame
- manager2master_plaintext  out  PLAINTEXT_WIDTH  FIFO head
- manager2master_valid  out  1  FIFO non-empty
- master2manager_ready  in  1  master pops head when valid
- drop_auth_cnt, drop_replay_cnt  out  DROP_CNT_WIDTH  saturating drop counters

## Operation
- Frame layout (decrypted): [MSB:CNTR+AUTH] plaintext, [CNTR+AUTH-1:AUTH] counter, [AUTH-1:0] tag.
- FSM: IDLE → REQ → WAIT_DEC → CHECK → IDLE.
  - IDLE: ready = init_done. On valid&&ready, register ciphertext, key, nonce and tag; go to REQ.
  - REQ: start = chacha2manager_ready (combinational, in REQ only). Leave for WAIT_DEC in the same cycle start is high.
  - WAIT_DEC: on chacha valid, register the decrypted message; go to CHECK.
  - CHECK: evaluate the tag and replay checks. On pass, push when the FIFO is not full or a pop occurs in the same cycle, then go to IDLE; otherwise hold in CHECK. On fail, increment the matching counter and go to IDLE. A tag failure takes precedence over a replay failure.
- Block count: reset 0; increments (mod 2^32) on every exit from CHECK, pass or drop. It holds its value on the request fields from REQ through WAIT_DEC.
- Request fields are constant from REQ until the chacha valid is seen.
- Replay check: a history-valid flag and last_cntr register. The first frame after reset passes and sets both. Later frames pass iff (cntr − last_cntr) mod 2^CNTR is in [1, 2^(CNTR−1)−1]. last_cntr updates only on pass.
- Drop counters saturate at all-ones.

## Timing
- Reset values: manager2slave_ready 0; start 0; manager2master_valid 0; drop counters 0; block count 0; FIFO empty; history cleared; state IDLE. init_done sets on the first clk edge after release, so ready rises 1 cycle after reset release.
- Minimum latency: handshake edge N → start high in cycle N+1 → chacha valid at cycle K → CHECK at K+1 → manager2master_valid at K+2.
- FIFO is first-word-fall-through. Push and pop in the same cycle are both legal, including when full.
- Reset asserted mid-frame aborts immediately. The in-flight frame is lost and a late chacha valid after reset is ignored (the FSM is in IDLE).
- chacha valid outside WAIT_DEC is ignored.

## Configuration
- RX_REPLAY_CHECK_EN defined: replay window check, history flag and last_cntr are present.
- Not defined: the counter field is ignored, all tag-passing frames are pushed, and drop_replay_cnt is tied to 0.

## Structure
- Package rx_auth_pkg: default widths, frame field offset constants, FSM state enum.
- Sub-module rx_plaintext_fifo (parameter depth/width, FWFT, push/pop/full/empty).

## Test plan
- Reset release, then frame with cntr=5 and tag=cfg_auth_tag=0xA5, ChaCha valid 3 cycles after start → plaintext out at K+2, block_count=0 on request then 1.
- Tag mismatch (tag 0x00, cfg 0xA5) → no FIFO push, drop_auth_cnt=1, FSM back in IDLE.
- Counters 5, 5, 4, 6 (replay on) → passes 5 and 6; drop_replay_cnt=2. Counters 0xFFFF then 0x0002 → both pass (wrap).
- master2manager_ready=0, 5 passing frames, depth 4 → 4 queued, FSM holds in CHECK. Raise ready → 5th pushed the same cycle as the pop.
- Reset asserted in WAIT_DEC, then chacha valid arrives → no output, all outputs at reset values, next frame processed normally with block_count 0.
- RX_REPLAY_CHECK_EN undefined, duplicate counters → all pass, drop_replay_cnt=0.
